// File: rtl/cache_simple_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_simple_ctrl_if
// Groups the four val/rdy streams around the cache controller:
//   proc2cache_reqstream   processor -> cache request
//   proc2cache_respstream  cache -> processor response
//   cache2mem_reqstream    cache -> memory request
//   cache2mem_respstream   memory -> cache response
// Modports:
//   master : the cache controller side (drives cache-owned val/rdy)
//   slave  : the environment side (processor and memory)
//
// Handshake rule on every stream: a transfer happens on a rising clock edge
// where val and rdy are both 1. The producer keeps val (and its payload)
// stable until that edge. rdy never depends on val in the same cycle.
// ---------------------------------------------------------------------------
interface cache_simple_ctrl_if;
    logic proc2cache_reqstream_val;
    logic proc2cache_reqstream_rdy;
    logic proc2cache_respstream_val;
    logic proc2cache_respstream_rdy;
    logic cache2mem_reqstream_val;
    logic cache2mem_reqstream_rdy;
    logic cache2mem_respstream_val;
    logic cache2mem_respstream_rdy;

    modport master (
        input  proc2cache_reqstream_val,
        output proc2cache_reqstream_rdy,
        output proc2cache_respstream_val,
        input  proc2cache_respstream_rdy,
        output cache2mem_reqstream_val,
        input  cache2mem_reqstream_rdy,
        input  cache2mem_respstream_val,
        output cache2mem_respstream_rdy
    );

    modport slave (
        output proc2cache_reqstream_val,
        input  proc2cache_reqstream_rdy,
        input  proc2cache_respstream_val,
        output proc2cache_respstream_rdy,
        input  cache2mem_reqstream_val,
        output cache2mem_reqstream_rdy,
        output cache2mem_respstream_val,
        input  cache2mem_respstream_rdy
    );
endinterface

// File: rtl/cache_simple_ctrl.sv
// ---------------------------------------------------------------------------
// cache_simple_ctrl
// Control unit of a blocking direct-mapped, write-back, write-allocate cache
// (p_num_lines lines of 16 B). It sequences one processor request at a time,
// owns the per-line valid/dirty bits and drives the datapath enables/muxes.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   hs (master)           val/rdy of proc req/resp and mem req/resp streams
//   cachereq_type/addr    registered request fields from the datapath
//   tag_match             tag array read-out equals request tag
//   *_reg_en, *_ren/wen   datapath register and array enables
//   data_array_wdata_sel  0 request data (byte-enabled), 1 refill line
//   memreq_addr_sel       0 refill address, 1 evict address
//   memreq_type           0 read, 1 write
//   cacheresp_type/hit    response type (echo) and hit flag
//   dbg_state_o           current FSM state
//   dbg_valid_o/dirty_o   per-line valid / dirty bits
// ---------------------------------------------------------------------------
module cache_simple_ctrl #(
    parameter int p_num_lines = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    cache_simple_ctrl_if.master    hs,
    input  logic [2:0]             cachereq_type,
    input  logic [31:0]            cachereq_addr,
    input  logic                   tag_match,
    output logic                   cachereq_reg_en,
    output logic                   memresp_reg_en,
    output logic                   evict_addr_reg_en,
    output logic                   read_data_reg_en,
    output logic                   tag_array_ren,
    output logic                   tag_array_wen,
    output logic                   data_array_ren,
    output logic                   data_array_wen,
    output logic                   data_array_wdata_sel,
    output logic                   memreq_addr_sel,
    output logic [2:0]             memreq_type,
    output logic [2:0]             cacheresp_type,
    output logic [1:0]             cacheresp_hit,
    output logic [3:0]             dbg_state_o,
    output logic [p_num_lines-1:0] dbg_valid_o,
    output logic [p_num_lines-1:0] dbg_dirty_o
);

    localparam int IW = $clog2(p_num_lines);

    typedef enum logic [3:0] {
        S_IDLE              = 4'd0,
        S_TAG_CHECK         = 4'd1,
        S_INIT_DATA_ACCESS  = 4'd2,
        S_READ_DATA_ACCESS  = 4'd3,
        S_WRITE_DATA_ACCESS = 4'd4,
        S_EVICT_PREPARE     = 4'd5,
        S_EVICT_REQUEST     = 4'd6,
        S_EVICT_WAIT        = 4'd7,
        S_REFILL_REQUEST    = 4'd8,
        S_REFILL_WAIT       = 4'd9,
        S_REFILL_UPDATE     = 4'd10,
        S_WAIT              = 4'd11
    } state_t;

    state_t                 state_q;
    logic [p_num_lines-1:0] valid_q;
    logic [p_num_lines-1:0] dirty_q;
    logic                   hit_q;

    logic [IW-1:0] idx;
    logic          hit;
    logic          req_write;
    logic          req_init;
    logic          unused_addr_bits;

    assign idx       = cachereq_addr[4 +: IW];
    assign hit       = tag_match & valid_q[idx];
    assign req_write = (cachereq_type == 3'd1);
    // Any type other than write or init behaves as a read.
    assign req_init  = (cachereq_type == 3'd2);

    assign unused_addr_bits = ^{cachereq_addr[31:4+IW], cachereq_addr[3:0]};

    // State, line status bits and the registered hit flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs.proc2cache_reqstream_val) state_q <= S_TAG_CHECK;
                end
                S_TAG_CHECK: begin
                    hit_q <= hit & ~req_init;
                    if (req_init) begin
                        state_q <= S_INIT_DATA_ACCESS;
                    end else if (hit) begin
                        state_q <= req_write ? S_WRITE_DATA_ACCESS : S_READ_DATA_ACCESS;
                    end else if (valid_q[idx] & dirty_q[idx]) begin
                        // Victim holds modified data: write it back first.
                        state_q <= S_EVICT_PREPARE;
                    end else begin
                        state_q <= S_REFILL_REQUEST;
                    end
                end
                S_INIT_DATA_ACCESS: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_READ_DATA_ACCESS: begin
                    state_q <= S_WAIT;
                end
                S_WRITE_DATA_ACCESS: begin
                    dirty_q[idx] <= 1'b1;
                    state_q      <= S_WAIT;
                end
                S_EVICT_PREPARE: begin
                    state_q <= S_EVICT_REQUEST;
                end
                S_EVICT_REQUEST: begin
                    if (hs.cache2mem_reqstream_rdy) state_q <= S_EVICT_WAIT;
                end
                S_EVICT_WAIT: begin
                    if (hs.cache2mem_respstream_val) state_q <= S_REFILL_REQUEST;
                end
                S_REFILL_REQUEST: begin
                    if (hs.cache2mem_reqstream_rdy) state_q <= S_REFILL_WAIT;
                end
                S_REFILL_WAIT: begin
                    if (hs.cache2mem_respstream_val) state_q <= S_REFILL_UPDATE;
                end
                S_REFILL_UPDATE: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                    // The write then merges on top of the clean refilled line.
                    state_q <= req_write ? S_WRITE_DATA_ACCESS : S_READ_DATA_ACCESS;
                end
                S_WAIT: begin
                    if (hs.proc2cache_respstream_rdy) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the control outputs. Gated by reset so that every
    // output reads 0 while reset is held, even though IDLE normally
    // advertises rdy.
    always_comb begin
        hs.proc2cache_reqstream_rdy  = 1'b0;
        hs.proc2cache_respstream_val = 1'b0;
        hs.cache2mem_reqstream_val   = 1'b0;
        hs.cache2mem_respstream_rdy  = 1'b0;
        cachereq_reg_en      = 1'b0;
        memresp_reg_en       = 1'b0;
        evict_addr_reg_en    = 1'b0;
        read_data_reg_en     = 1'b0;
        tag_array_ren        = 1'b0;
        tag_array_wen        = 1'b0;
        data_array_ren       = 1'b0;
        data_array_wen       = 1'b0;
        data_array_wdata_sel = 1'b0;
        memreq_addr_sel      = 1'b0;
        memreq_type          = 3'd0;
        cacheresp_hit        = 2'd0;
        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    hs.proc2cache_reqstream_rdy = 1'b1;
                    cachereq_reg_en             = 1'b1;
                end
                S_TAG_CHECK: begin
                    tag_array_ren = 1'b1;
                end
                S_INIT_DATA_ACCESS: begin
                    tag_array_wen  = 1'b1;
                    data_array_wen = 1'b1;
                end
                S_READ_DATA_ACCESS: begin
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                end
                S_WRITE_DATA_ACCESS: begin
                    data_array_wen = 1'b1;
                end
                S_EVICT_PREPARE: begin
                    tag_array_ren     = 1'b1;
                    data_array_ren    = 1'b1;
                    evict_addr_reg_en = 1'b1;
                    read_data_reg_en  = 1'b1;
                end
                S_EVICT_REQUEST: begin
                    hs.cache2mem_reqstream_val = 1'b1;
                    memreq_type                = 3'd1;
                    memreq_addr_sel            = 1'b1;
                end
                S_EVICT_WAIT: begin
                    hs.cache2mem_respstream_rdy = 1'b1;
                end
                S_REFILL_REQUEST: begin
                    hs.cache2mem_reqstream_val = 1'b1;
                end
                S_REFILL_WAIT: begin
                    hs.cache2mem_respstream_rdy = 1'b1;
                    memresp_reg_en              = 1'b1;
                end
                S_REFILL_UPDATE: begin
                    tag_array_wen        = 1'b1;
                    data_array_wen       = 1'b1;
                    data_array_wdata_sel = 1'b1;
                end
                S_WAIT: begin
                    hs.proc2cache_respstream_val = 1'b1;
                    cacheresp_hit                = {1'b0, hit_q};
                end
                default: begin
                end
            endcase
        end
    end

    assign cacheresp_type = cachereq_type;
    assign dbg_state_o    = state_q;
    assign dbg_valid_o    = valid_q;
    assign dbg_dirty_o    = dirty_q;

endmodule

// File: tb/tb_cache_simple_ctrl.sv
module tb_cache_simple_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_simple_ctrl_if hs();

    logic [2:0]  cachereq_type;
    logic [31:0] cachereq_addr;
    logic        tag_match;
    logic        cachereq_reg_en, memresp_reg_en, evict_addr_reg_en, read_data_reg_en;
    logic        tag_array_ren, tag_array_wen, data_array_ren, data_array_wen;
    logic        data_array_wdata_sel, memreq_addr_sel;
    logic [2:0]  memreq_type, cacheresp_type;
    logic [1:0]  cacheresp_hit;
    logic [3:0]  dbg_state;
    logic [15:0] dbg_valid, dbg_dirty;

    cache_simple_ctrl #(.p_num_lines(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .hs                   (hs),
        .cachereq_type        (cachereq_type),
        .cachereq_addr        (cachereq_addr),
        .tag_match            (tag_match),
        .cachereq_reg_en      (cachereq_reg_en),
        .memresp_reg_en       (memresp_reg_en),
        .evict_addr_reg_en    (evict_addr_reg_en),
        .read_data_reg_en     (read_data_reg_en),
        .tag_array_ren        (tag_array_ren),
        .tag_array_wen        (tag_array_wen),
        .data_array_ren       (data_array_ren),
        .data_array_wen       (data_array_wen),
        .data_array_wdata_sel (data_array_wdata_sel),
        .memreq_addr_sel      (memreq_addr_sel),
        .memreq_type          (memreq_type),
        .cacheresp_type       (cacheresp_type),
        .cacheresp_hit        (cacheresp_hit),
        .dbg_state_o          (dbg_state),
        .dbg_valid_o          (dbg_valid),
        .dbg_dirty_o          (dbg_dirty)
    );

    // Every controller output except cacheresp_type, for reset checks.
    logic [22:0] all_outs;
    assign all_outs = {hs.proc2cache_reqstream_rdy, hs.proc2cache_respstream_val,
                       hs.cache2mem_reqstream_val, hs.cache2mem_respstream_rdy,
                       cachereq_reg_en, memresp_reg_en, evict_addr_reg_en, read_data_reg_en,
                       tag_array_ren, tag_array_wen, data_array_ren, data_array_wen,
                       data_array_wdata_sel, memreq_addr_sel, memreq_type, cacheresp_hit,
                       dbg_state};

    // ---------------- reference model: line-level cache contents ----------
    logic [23:0] m_tag [16];
    bit          m_valid [16];
    bit          m_dirty [16];

    // The bench plays the tag array: compare against the model's stored tag.
    assign tag_match = (m_tag[cachereq_addr[7:4]] == cachereq_addr[31:8]);

    // Expected memory requests of the current transaction: {type, addr_sel}.
    logic [3:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_lines();
        logic [15:0] mv, md;
        for (int i = 0; i < 16; i++) begin
            mv[i] = m_valid[i];
            md[i] = m_dirty[i];
        end
        check("valid_bits", dbg_valid, mv);
        check("dirty_bits", dbg_dirty, md);
    endtask

    task automatic drive_idle_inputs();
        hs.proc2cache_reqstream_val  = 1'b0;
        hs.proc2cache_respstream_rdy = 1'b0;
        hs.cache2mem_reqstream_rdy   = 1'b0;
        hs.cache2mem_respstream_val  = 1'b0;
    endtask

    // One processor transaction with memory/processor back-pressure.
    // Latency is counted in cycles after the accepting edge; the first cycle
    // showing response valid is the latency.
    task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr,
                           input int req_stall, input int resp_stall,
                           input int proc_stall, input bit abort_in_refill);
        int idx, base, lat_exp, n, n_req, n_req_exp, refills, refills_exp;
        int qs, rs, ps;
        bit is_write, is_init, hit, dirty_miss, pending, got_resp, done, aborted;
        logic [3:0] op;
        logic [1:0] first_hit;

        idx        = addr[7:4];
        is_write   = (typ == 3'd1);
        is_init    = (typ == 3'd2);
        hit        = !is_init && m_valid[idx] && (m_tag[idx] == addr[31:8]);
        dirty_miss = !is_init && !hit && m_valid[idx] && m_dirty[idx];
        exp_q.delete();
        if (is_init || hit) begin
            base = 3;
        end else if (dirty_miss) begin
            base = 9;
            exp_q.push_back({3'd1, 1'b1});
            exp_q.push_back({3'd0, 1'b0});
        end else begin
            base = 6;
            exp_q.push_back({3'd0, 1'b0});
        end
        n_req_exp   = exp_q.size();
        lat_exp     = base + n_req_exp * (req_stall + resp_stall);
        refills_exp = (!is_init && !hit) ? 1 : 0;

        @(negedge clk);
        check("idle_req_rdy", hs.proc2cache_reqstream_rdy, 1);
        cachereq_type = typ;
        cachereq_addr = addr;
        hs.proc2cache_reqstream_val = 1'b1;
        @(negedge clk);
        hs.proc2cache_reqstream_val = 1'b0;

        n = 1; n_req = 0; refills = 0; qs = 0; rs = 0; ps = 0;
        pending = 0; got_resp = 0; done = 0; aborted = 0; first_hit = 2'd0;
        while (!done && n < 400) begin
            if (abort_in_refill && hs.cache2mem_respstream_rdy && memresp_reg_en) begin
                reset = 1'b0;
                drive_idle_inputs();
                #1;
                check("abort_outs_zero", all_outs, 0);
                check("abort_resp_type", cacheresp_type, typ);
                @(negedge clk);
                check("abort_outs_held", all_outs, 0);
                reset = 1'b1;
                #1;
                check("abort_idle_state", dbg_state, 0);
                check("abort_req_rdy", hs.proc2cache_reqstream_rdy, 1);
                for (int i = 0; i < 16; i++) begin
                    m_valid[i] = 0;
                    m_dirty[i] = 0;
                end
                check_lines();
                aborted = 1;
                done    = 1;
            end else begin
                if (tag_array_wen && data_array_wen && data_array_wdata_sel) refills++;

                // Memory response for a request accepted in an earlier cycle.
                hs.cache2mem_respstream_val = 1'b0;
                if (pending) begin
                    if (rs < resp_stall) begin
                        rs++;
                    end else begin
                        hs.cache2mem_respstream_val = 1'b1;
                        if (hs.cache2mem_respstream_rdy) begin
                            pending = 0;
                            rs      = 0;
                        end
                    end
                end

                // Memory request side with back-pressure.
                hs.cache2mem_reqstream_rdy = 1'b0;
                if (hs.cache2mem_reqstream_val) begin
                    op = {memreq_type, memreq_addr_sel};
                    if (qs < req_stall) begin
                        qs++;
                        if (exp_q.size() > 0) check("mem_req_hold", op, exp_q[0]);
                    end else begin
                        hs.cache2mem_reqstream_rdy = 1'b1;
                        qs      = 0;
                        pending = 1;
                        n_req++;
                        if (exp_q.size() > 0) check("mem_req_op", op, exp_q.pop_front());
                    end
                end

                // Processor response with optional back-pressure.
                hs.proc2cache_respstream_rdy = 1'b0;
                if (hs.proc2cache_respstream_val) begin
                    if (!got_resp) begin
                        got_resp  = 1;
                        first_hit = cacheresp_hit;
                        check("resp_latency", n, lat_exp);
                        check("resp_type", cacheresp_type, typ);
                        check("resp_hit", cacheresp_hit, {1'b0, hit});
                    end else begin
                        check("resp_hold_hit", cacheresp_hit, first_hit);
                        check("resp_hold_type", cacheresp_type, typ);
                    end
                    check("busy_req_rdy", hs.proc2cache_reqstream_rdy, 0);
                    if (ps < proc_stall) begin
                        ps++;
                    end else begin
                        hs.proc2cache_respstream_rdy = 1'b1;
                        done = 1;
                    end
                end
                if (!done) begin
                    @(negedge clk);
                    n++;
                end
            end
        end

        check("txn_done", done, 1);
        if (!aborted) begin
            check("mem_req_count", n_req, n_req_exp);
            check("refill_updates", refills, refills_exp);
            @(negedge clk);
            drive_idle_inputs();
            check("back_to_idle", dbg_state, 0);
            if (is_init) begin
                m_valid[idx] = 1;
                m_dirty[idx] = 0;
                m_tag[idx]   = addr[31:8];
            end else if (hit) begin
                if (is_write) m_dirty[idx] = 1;
            end else begin
                m_valid[idx] = 1;
                m_dirty[idx] = is_write;
                m_tag[idx]   = addr[31:8];
            end
            check_lines();
        end
    endtask

    initial begin
        logic [2:0]  typ;
        logic [31:0] addr;
        int          t;

        for (int i = 0; i < 16; i++) begin
            m_tag[i]   = 24'd0;
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        reset         = 1'b0;
        cachereq_type = 3'd5;
        cachereq_addr = 32'd0;
        drive_idle_inputs();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outs_zero", all_outs, 0);
        check("rst_resp_type_follow", cacheresp_type, 3'd5);
        reset = 1'b1;
        #1;
        check("rst_idle_state", dbg_state, 0);
        check("rst_req_rdy", hs.proc2cache_reqstream_rdy, 1);
        check("rst_reg_en", cachereq_reg_en, 1);
        check_lines();

        // Directed scenarios.
        run_txn(3'd2, 32'h0000_1000, 0, 0, 0, 0);   // init
        run_txn(3'd0, 32'h0000_1000, 0, 0, 0, 0);   // read hit, 3 cycles
        run_txn(3'd0, 32'h0000_2000, 0, 0, 0, 0);   // clean miss
        run_txn(3'd1, 32'h0000_3004, 0, 0, 0, 0);   // write miss -> dirty
        run_txn(3'd0, 32'h0000_4004, 0, 0, 0, 0);   // dirty miss -> evict + refill
        run_txn(3'd0, 32'h0000_4004, 0, 0, 5, 0);   // hit, response held 5 cycles
        run_txn(3'd0, 32'h0000_7020, 4, 0, 0, 0);   // refill request stalled 4 cycles
        run_txn(3'd6, 32'h0000_7020, 0, 0, 0, 0);   // unknown type behaves as read
        run_txn(3'd2, 32'h0000_5010, 0, 0, 0, 0);   // init line 1
        run_txn(3'd0, 32'h0000_6010, 0, 2, 0, 1);   // reset during refill wait
        run_txn(3'd0, 32'h0000_5010, 0, 0, 0, 0);   // previously initialised -> miss

        // Randomized traffic over a few tags per index.
        for (int k = 0; k < 60; k++) begin
            t = $urandom_range(0, 9);
            if (t < 4)      typ = 3'd0;
            else if (t < 7) typ = 3'd1;
            else if (t < 9) typ = 3'd2;
            else            typ = 3'($urandom_range(3, 7));
            addr = {24'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            run_txn(typ, addr, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_simple_ctrl.md
Name: cache_simple_ctrl

Overview:
Control unit for the simple blocking direct-mapped cache: 16 lines × 16 B, write-back, write-allocate. Sits beside the cache datapath and drives its register enables, tag/data array enables and datapath muxes. Owns the val/rdy handshakes on all four streams (proc req/resp, mem req/resp) and the per-line valid and dirty state. Accepts one processor request at a time; no overlap between transactions.

Parameters:
p_num_lines, 16, number of cache lines; the index is addr[7:4], log2(p_num_lines) bits.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
proc2cache_reqstream_val  in  1  processor request valid
proc2cache_reqstream_rdy  out  1  cache ready to accept a request
proc2cache_respstream_val  out  1  cache response valid
proc2cache_respstream_rdy  in  1  processor ready for a response
cache2mem_reqstream_val  out  1  memory request valid
cache2mem_reqstream_rdy  in  1  memory ready to accept a request
cache2mem_respstream_val  in  1  memory response valid
cache2mem_respstream_rdy  out  1  cache ready for a memory response
cachereq_type  in  3  registered request type from the datapath (0 read, 1 write, 2 init)
cachereq_addr  in  32  registered request address from the datapath
tag_match  in  1  tag array read-out equals the request tag (combinational)
cachereq_reg_en  out  1  latch the incoming processor request
memresp_reg_en  out  1  latch the memory refill line
evict_addr_reg_en  out  1  latch the victim tag/address
read_data_reg_en  out  1  latch the selected read word
tag_array_ren / tag_array_wen  out  1 each  tag array read / write enable
data_array_ren / data_array_wen  out  1 each  data array read / write enable
data_array_wdata_sel  out  1  data array write source: 0 replicated request data (byte-enabled), 1 memory line (full line)
memreq_addr_sel  out  1  memory request address: 0 refill address, 1 evict address
memreq_type  out  3  memory request type: 0 read, 1 write
cacheresp_type  out  3  response type; echoes cachereq_type
cacheresp_hit  out  2  1 on hit, 0 on miss; always 0 for init

Behaviour:
- Reset (reset=0, asynchronous): state←IDLE; all valid[] and dirty[] bits←0. While reset is asserted, every output is 0 except cacheresp_type, which follows cachereq_type. If reset asserts mid-transaction, the transaction is abandoned; no response is issued.
- All enables default to 0 in every state unless listed below.
- idx = cachereq_addr[7:4]; hit = tag_match & valid[idx].
- IDLE: proc2cache_reqstream_rdy=1 and cachereq_reg_en=1. Go to TAG_CHECK when proc2cache_reqstream_val=1.
- TAG_CHECK: tag_array_ren=1.
  - init → INIT_DATA_ACCESS.
  - hit, read → READ_DATA_ACCESS.
  - hit, write → WRITE_DATA_ACCESS.
  - miss with valid[idx] & dirty[idx] → EVICT_PREPARE.
  - any other miss → REFILL_REQUEST.
  - Register hit_reg = hit (forced to 0 for init).
- INIT_DATA_ACCESS: tag_array_wen=1, data_array_wen=1, sel=0. valid[idx]←1, dirty[idx]←0. → WAIT.
- READ_DATA_ACCESS: data_array_ren=1, read_data_reg_en=1. → WAIT.
- WRITE_DATA_ACCESS: data_array_wen=1, sel=0. dirty[idx]←1. → WAIT.
- EVICT_PREPARE: tag_array_ren=1, data_array_ren=1, evict_addr_reg_en=1, read_data_reg_en=1. → EVICT_REQUEST.
- EVICT_REQUEST: cache2mem_reqstream_val=1, memreq_type=1, memreq_addr_sel=1. Stay until cache2mem_reqstream_rdy=1, then → EVICT_WAIT.
- EVICT_WAIT: cache2mem_respstream_rdy=1. On cache2mem_respstream_val → REFILL_REQUEST.
- REFILL_REQUEST: cache2mem_reqstream_val=1, memreq_type=0, memreq_addr_sel=0. On cache2mem_reqstream_rdy → REFILL_WAIT.
- REFILL_WAIT: cache2mem_respstream_rdy=1, memresp_reg_en=1. On cache2mem_respstream_val → REFILL_UPDATE.
- REFILL_UPDATE: tag_array_wen=1, data_array_wen=1, sel=1. valid[idx]←1, dirty[idx]←0. → READ_DATA_ACCESS for a read, WRITE_DATA_ACCESS for a write.
- WAIT: proc2cache_respstream_val=1, cacheresp_hit=hit_reg. On proc2cache_respstream_rdy → IDLE. proc2cache_reqstream_rdy stays 0 until the state is back in IDLE, so there is no same-cycle accept.
- Latency (request accepted to response valid):
  - init or hit: 3 cycles (TAG_CHECK, DATA_ACCESS, WAIT).
  - clean miss: 6 cycles plus memory stalls.
  - dirty miss: 9 cycles plus memory stalls.
- Memory-side val stays asserted under back-pressure; request fields are held stable while val=1 and rdy=0.
- Unknown cachereq_type values are treated as a read.

Test Plan:
- Init 0x1000 then read 0x1000 → the read response arrives 3 cycles after accept, with cacheresp_hit=1 and type=0. The init response has hit=0 and type=2.
- Read 0x2000 on a cold cache → exactly one memory read (type=0, refill address); REFILL_UPDATE is taken, then the response comes back with hit=0.
- Write 0x3004, then read 0x4004 (same index 0, different tag) → first a memory write with the evict address, then a memory read; the read response has hit=0, and dirty[0] reads 0 afterwards.
- Hold proc2cache_respstream_rdy=0 for 5 cycles in WAIT → respstream val held at 1 with stable type/hit; proc2cache_reqstream_rdy=0 throughout.
- Hold cache2mem_reqstream_rdy=0 for 4 cycles during REFILL_REQUEST → val held at 1; no state advance until rdy=1.
- Assert reset=0 during REFILL_WAIT → all outputs 0 immediately (cacheresp_type excepted); after release, state is IDLE, reqstream rdy=1, and a read of the previously initialised line misses.
